// File: rtl/mx_block_max_stream.sv
// mx_block_max_stream
//
// Streaming shared-exponent extractor for MX block formats. A block of
// `length` unsigned exponents arrives as `length/lanes` beats of `lanes`
// values. Each beat is reduced by a pipelined comparator tree, then the
// per-beat winners are accumulated across the block. One result per block
// gives the block maximum and the block index of its first occurrence.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_exps     lanes x width exponents, lane 0 = lowest index in the beat
//   i_mask     per-lane valid; masked lanes count as value 0
//   i_valid    beat valid
//   o_ready    beat accepted when i_valid && o_ready
//   o_e_max    block maximum exponent
//   o_max_idx  block index of the first maximum
//   o_valid    result valid
//   i_ready    result consumed when o_valid && i_ready
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The whole datapath shares one advance enable
// (en = !o_valid || i_ready), so o_ready is en and every pipeline register,
// including its valid/tag bits, moves only when en is high. Nothing needs
// a skid buffer because upstream sees the stall in the same cycle.

module mx_block_max_stream #(
  parameter int width   = 8,
  parameter int lanes   = 8,
  parameter int length  = 32,
  parameter int pl_freq = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [lanes*width-1:0]    i_exps,
  input  logic [lanes-1:0]          i_mask,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [width-1:0]          o_e_max,
  output logic [$clog2(length)-1:0] o_max_idx,
  output logic                      o_valid,
  input  logic                      i_ready
);

  localparam int D  = $clog2(lanes);
  localparam int LW = D;
  localparam int IW = $clog2(length);
  localparam int B  = length / lanes;
  localparam int BW = (B > 1) ? $clog2(B) : 1;

  // vld marks an unmasked source lane; it only matters for breaking a tie
  // between a masked zero and an unmasked zero.
  typedef struct packed {
    logic [width-1:0] val;
    logic             vld;
    logic [LW-1:0]    lane;
  } node_t;

  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic [BW-1:0] beat;
  } tag_t;

  // The right input (higher lanes) wins only when strictly larger, or when
  // equal and it is unmasked while the left one is masked.
  function automatic node_t pick(input node_t a, input node_t b);
    node_t r;
    r = a;
    if ((b.val > a.val) || ((b.val == a.val) && b.vld && !a.vld)) begin
      r = b;
    end
    return r;
  endfunction

  logic en;
  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  // Input beat counter
  logic [BW-1:0] bcnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bcnt <= '0;
    end else if (en && i_valid) begin
      if (bcnt == BW'(B - 1)) begin
        bcnt <= '0;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // Comparator tree, heap-indexed: node i has children 2i (lower lanes)
  // and 2i+1; leaves sit at lanes..2*lanes-1 and the root at 1.
  // s[i] is the node output after its optional pipeline register.
  node_t s [1:2*lanes-1];
  tag_t  t [0:D];

  for (genvar j = 0; j < lanes; j++) begin : g_leaf
    assign s[lanes+j] = '{val:  i_mask[j] ? i_exps[j*width +: width] : '0,
                          vld:  i_mask[j],
                          lane: LW'(j)};
  end

  for (genvar i = 1; i < lanes; i++) begin : g_node
    // Tree level of node i: leaves are level 0, the root is level D.
    localparam int K = D - ($clog2(i + 1) - 1);
    node_t c;
    assign c = pick(s[2*i], s[2*i+1]);
    if ((K % pl_freq) == 0) begin : g_reg
      node_t r;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r <= '0;
        end else if (en) begin
          r <= c;
        end
      end
      assign s[i] = r;
    end else begin : g_comb
      assign s[i] = c;
    end
  end

  // Beat tags travel alongside the tree, registered at the same levels.
  assign t[0] = '{valid: i_valid,
                  first: (bcnt == '0),
                  last:  (bcnt == BW'(B - 1)),
                  beat:  bcnt};

  for (genvar k = 1; k <= D; k++) begin : g_tag
    if ((k % pl_freq) == 0) begin : g_reg
      tag_t r;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r <= '0;
        end else if (en) begin
          r <= t[k-1];
        end
      end
      assign t[k] = r;
    end else begin : g_comb
      assign t[k] = t[k-1];
    end
  end

  // Accumulator stage. acc_done flags that the registered acc now holds a
  // finished block, which the output stage picks up on the next advance.
  logic [width-1:0] acc_val;
  logic [IW-1:0]    acc_idx;
  logic             acc_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_val  <= '0;
      acc_idx  <= '0;
      acc_done <= 1'b0;
    end else if (en) begin
      acc_done <= t[D].valid && t[D].last;
      // Strict compare keeps the earlier beat on ties.
      if (t[D].valid && (t[D].first || (s[1].val > acc_val))) begin
        acc_val <= s[1].val;
        acc_idx <= (IW'(t[D].beat) << LW) | IW'(s[1].lane);
      end
    end
  end

  // Output register. When en is high either there is no pending result or
  // it is being consumed this edge, so it is replaced or dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_e_max   <= '0;
      o_max_idx <= '0;
    end else if (en) begin
      if (acc_done) begin
        o_valid   <= 1'b1;
        o_e_max   <= acc_val;
        o_max_idx <= acc_idx;
      end else begin
        o_valid   <= 1'b0;
      end
    end
  end

endmodule
